// File: rtl/sram_word_controller_if.sv
// Pipeline-side word bus and SRAM pin bundle for the word controller.
// slave = controller view, master = pipeline/pad-ring view.
interface sram_word_controller_if #(
  parameter int SRAM_ADDR_W = 18
);
  logic                   mem_read;
  logic                   mem_write;
  logic [31:0]            addr;
  logic [31:0]            wdata;
  logic [31:0]            rdata;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_o;
  logic [15:0]            sram_dq_i;
  logic                   sram_dq_oe;
  logic                   sram_we_n;
  logic                   sram_oe_n;

  modport slave (
    input  mem_read, mem_write, addr, wdata, sram_dq_i,
    output rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport master (
    output mem_read, mem_write, addr, wdata, sram_dq_i,
    input  rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_word_controller.sv
// Splits 32-bit MEM-stage accesses into low/high half-word phases on a
// 16-bit asynchronous SRAM, freezing the pipeline via ready while busy.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; ready follows the request
// LOW   | low half-word phase, WAIT_CYCLES long
// HIGH  | high half-word phase, WAIT_CYCLES long
// DONE  | one cycle with ready=1 so the pipeline advances; no re-accept
module sram_word_controller #(
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  sram_word_controller_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic                   op_q;
  logic [SRAM_ADDR_W-2:0] word_idx_q;
  logic [31:0]            wbuf_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [31:0]            rdata_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [15:0]            sram_dq_o_q;
  logic                   sram_dq_oe_q;
  logic                   sram_we_n_q;
  logic                   sram_oe_n_q;

  logic                   req;
  logic [SRAM_ADDR_W-2:0] req_idx;

  assign req     = bus.mem_read | bus.mem_write;
  assign req_idx = bus.addr[SRAM_ADDR_W:2];

  // Only IDLE looks at the live request; DONE releases the freeze for one edge.
  assign bus.ready      = (state_q == S_IDLE) ? !req : (state_q == S_DONE);
  assign bus.rdata      = rdata_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_dq_o  = sram_dq_o_q;
  assign bus.sram_dq_oe = sram_dq_oe_q;
  assign bus.sram_we_n  = sram_we_n_q;
  assign bus.sram_oe_n  = sram_oe_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      word_idx_q   <= '0;
      wbuf_q       <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            // Pin outputs are loaded here so they are valid in the first LOW cycle.
            op_q         <= bus.mem_write;
            word_idx_q   <= req_idx;
            wbuf_q       <= bus.wdata;
            cnt_q        <= '0;
            state_q      <= S_LOW;
            sram_addr_q  <= {req_idx, 1'b0};
            sram_dq_o_q  <= bus.mem_write ? bus.wdata[15:0] : 16'h0;
            sram_dq_oe_q <= bus.mem_write;
            sram_we_n_q  <= !bus.mem_write;
            sram_oe_n_q  <= bus.mem_write;
          end
        end
        S_LOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            state_q     <= S_HIGH;
            sram_addr_q <= {word_idx_q, 1'b1};
            sram_dq_o_q <= op_q ? wbuf_q[31:16] : 16'h0;
            if (!op_q) rdata_q[15:0] <= bus.sram_dq_i;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
            sram_dq_o_q <= op_q ? wbuf_q[15:0] : 16'h0;
          end
        end
        S_HIGH: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q        <= '0;
            state_q      <= S_DONE;
            sram_addr_q  <= '0;
            sram_dq_o_q  <= '0;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            if (!op_q) rdata_q[31:16] <= bus.sram_dq_i;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
            sram_dq_o_q <= op_q ? wbuf_q[31:16] : 16'h0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_word_controller.sv
// Directed bench for sram_word_controller (W=2) with a small behavioural SRAM.
module tb_sram_word_controller;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  logic [15:0] sram_mem [0:1023];

  sram_word_controller_if #(.SRAM_ADDR_W(18)) sif ();

  sram_word_controller #(
    .SRAM_ADDR_W(18),
    .WAIT_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sif.sram_we_n && sif.sram_dq_oe) sram_mem[sif.sram_addr[9:0]] <= sif.sram_dq_o;
  end

  assign sif.sram_dq_i = sif.sram_oe_n ? 16'h0 : sram_mem[sif.sram_addr[9:0]];

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (sif.ready !== 1'b1 || sif.sram_we_n !== 1'b1 || sif.sram_oe_n !== 1'b1 ||
        sif.sram_dq_oe !== 1'b0 || sif.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_asserted: ready=%b we_n=%b oe_n=%b dq_oe=%b rdata=%h, expected 1 1 1 0 00000000",
               sif.ready, sif.sram_we_n, sif.sram_oe_n, sif.sram_dq_oe, sif.rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (sif.ready !== 1'b1 || sif.sram_we_n !== 1'b1 || sif.sram_oe_n !== 1'b1 ||
          sif.sram_dq_oe !== 1'b0 || sif.rdata !== 32'h0 || sif.sram_addr !== 18'h0) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: ready=%b we_n=%b oe_n=%b dq_oe=%b rdata=%h addr=%h, expected 1 1 1 0 00000000 0",
                 c, sif.ready, sif.sram_we_n, sif.sram_oe_n, sif.sram_dq_oe, sif.rdata, sif.sram_addr);
      end
    end
  endtask

  task automatic test_write_w2;
    logic        e_ready;
    logic        e_we_n;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        sif.mem_write = 1'b1;
        sif.addr      = 32'h0000_0404;
        sif.wdata     = 32'hDEAD_BEEF;
      end
      #1;
      e_ready = (c == 5);
      e_we_n  = !(c >= 1 && c <= 4);
      e_addr  = (c == 1 || c == 2) ? 18'h202 : (c == 3 || c == 4) ? 18'h203 : 18'h0;
      e_dq    = (c == 1 || c == 2) ? 16'hBEEF : (c == 3 || c == 4) ? 16'hDEAD : 16'h0;
      tests_run++;
      if (sif.ready !== e_ready || sif.sram_we_n !== e_we_n || sif.sram_addr !== e_addr ||
          sif.sram_dq_o !== e_dq || sif.sram_dq_oe !== !e_we_n || sif.sram_oe_n !== 1'b1) begin
        tests_failed++;
        $display("FAIL write_w2 cycle %0d: ready=%b we_n=%b addr=%h dq=%h dq_oe=%b oe_n=%b, expected %b %b %h %h %b 1",
                 c, sif.ready, sif.sram_we_n, sif.sram_addr, sif.sram_dq_o, sif.sram_dq_oe, sif.sram_oe_n,
                 e_ready, e_we_n, e_addr, e_dq, !e_we_n);
      end
    end
    sif.mem_write = 1'b0;
  endtask

  task automatic test_read_back;
    logic        e_oe_n;
    logic [17:0] e_addr;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        sif.mem_read = 1'b1;
        sif.addr     = 32'h0000_0404;
      end
      #1;
      e_oe_n = !(c >= 1 && c <= 4);
      e_addr = (c == 1 || c == 2) ? 18'h202 : (c == 3 || c == 4) ? 18'h203 : 18'h0;
      tests_run++;
      if (sif.sram_oe_n !== e_oe_n || sif.sram_addr !== e_addr || sif.sram_we_n !== 1'b1 ||
          sif.sram_dq_oe !== 1'b0 || sif.ready !== (c == 5)) begin
        tests_failed++;
        $display("FAIL read_back cycle %0d: oe_n=%b addr=%h we_n=%b dq_oe=%b ready=%b, expected %b %h 1 0 %b",
                 c, sif.sram_oe_n, sif.sram_addr, sif.sram_we_n, sif.sram_dq_oe, sif.ready,
                 e_oe_n, e_addr, (c == 5));
      end
      if (c == 5) begin
        tests_run++;
        if (sif.rdata !== 32'hDEAD_BEEF) begin
          tests_failed++;
          $display("FAIL read_back_data: rdata=%h, expected deadbeef", sif.rdata);
        end
      end
    end
    sif.mem_read = 1'b0;
  endtask

  task automatic test_both_and_change;
    logic [17:0] e_addr;
    logic        e_we_n;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        sif.mem_read  = 1'b1;
        sif.mem_write = 1'b1;
        sif.addr      = 32'h0000_0008;
        sif.wdata     = 32'h1234_5678;
      end
      if (c == 2) sif.addr = 32'h0000_0010;
      #1;
      e_we_n = !(c >= 1 && c <= 4);
      e_addr = (c == 1 || c == 2) ? 18'h4 : (c == 3 || c == 4) ? 18'h5 : 18'h0;
      tests_run++;
      if (sif.sram_we_n !== e_we_n || sif.sram_addr !== e_addr || sif.sram_oe_n !== 1'b1) begin
        tests_failed++;
        $display("FAIL both_req cycle %0d: we_n=%b addr=%h oe_n=%b, expected %b %h 1",
                 c, sif.sram_we_n, sif.sram_addr, sif.sram_oe_n, e_we_n, e_addr);
      end
    end
    sif.mem_read  = 1'b0;
    sif.mem_write = 1'b0;
    @(negedge clk);
    tests_run++;
    if (sram_mem[4] !== 16'h5678 || sram_mem[5] !== 16'h1234) begin
      tests_failed++;
      $display("FAIL both_req_mem: mem[4]=%h mem[5]=%h, expected 5678 1234", sram_mem[4], sram_mem[5]);
    end
  endtask

  task automatic test_back_to_back;
    int we_cycles;
    we_cycles = 0;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (c == 0) begin
        sif.mem_write = 1'b1;
        sif.addr      = 32'h0;
        sif.wdata     = 32'hCAFE_F00D;
      end
      if (c == 6) begin
        sif.mem_write = 1'b0;
        sif.mem_read  = 1'b1;
      end
      #1;
      if (!sif.sram_we_n) we_cycles++;
      if (c == 5 || c == 6 || c == 7) begin
        tests_run++;
        if (sif.ready !== (c == 5) || sif.sram_oe_n !== (c != 7)) begin
          tests_failed++;
          $display("FAIL b2b_start cycle %0d: ready=%b oe_n=%b, expected %b %b",
                   c, sif.ready, sif.sram_oe_n, (c == 5), (c != 7));
        end
      end
      if (c == 11) begin
        tests_run++;
        if (sif.rdata !== 32'hCAFE_F00D || sif.ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_rdata: rdata=%h ready=%b, expected cafef00d 1", sif.rdata, sif.ready);
        end
      end
    end
    sif.mem_read = 1'b0;
    tests_run++;
    if (we_cycles != 4) begin
      tests_failed++;
      $display("FAIL b2b_write_count: we_n low cycles=%0d, expected 4", we_cycles);
    end
  endtask

  task automatic test_reset_mid_write;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        sif.mem_write = 1'b1;
        sif.addr      = 32'h0000_0020;
        sif.wdata     = 32'h1111_2222;
      end
      if (c == 3) begin
        rst_n         = 1'b0;
        sif.mem_write = 1'b0;
      end
      if (c == 4) rst_n = 1'b1;
      if (c == 5) begin
        sif.mem_read = 1'b1;
        sif.addr     = 32'h0;
      end
      #1;
      if (c == 2) begin
        tests_run++;
        if (sif.sram_we_n !== 1'b0 || sif.sram_addr !== 18'h10) begin
          tests_failed++;
          $display("FAIL rst_mid_pre: we_n=%b addr=%h, expected 0 010", sif.sram_we_n, sif.sram_addr);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (sif.sram_we_n !== 1'b1 || sif.sram_dq_oe !== 1'b0 || sif.ready !== 1'b1 || sif.sram_addr !== 18'h0) begin
          tests_failed++;
          $display("FAIL rst_mid_assert: we_n=%b dq_oe=%b ready=%b addr=%h, expected 1 0 1 0",
                   sif.sram_we_n, sif.sram_dq_oe, sif.ready, sif.sram_addr);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (sif.ready !== 1'b1 || sif.rdata !== 32'h0 || sif.sram_we_n !== 1'b1) begin
          tests_failed++;
          $display("FAIL rst_mid_release: ready=%b rdata=%h we_n=%b, expected 1 00000000 1",
                   sif.ready, sif.rdata, sif.sram_we_n);
        end
      end
      if (c == 5 || c == 6) begin
        tests_run++;
        if (sif.ready !== 1'b0 || sif.sram_oe_n !== (c == 5)) begin
          tests_failed++;
          $display("FAIL rst_mid_restart cycle %0d: ready=%b oe_n=%b, expected 0 %b",
                   c, sif.ready, sif.sram_oe_n, (c == 5));
        end
      end
      if (c == 10) begin
        tests_run++;
        if (sif.rdata !== 32'hCAFE_F00D || sif.ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL rst_mid_read: rdata=%h ready=%b, expected cafef00d 1", sif.rdata, sif.ready);
        end
      end
    end
    sif.mem_read = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    sif.mem_read  = 1'b0;
    sif.mem_write = 1'b0;
    sif.addr      = 32'h0;
    sif.wdata     = 32'h0;
    test_reset();
    test_write_w2();
    test_read_back();
    test_both_and_change();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_word_controller.md
# sram_word_controller

Sequences 32-bit word accesses from the MEM stage onto a 16-bit asynchronous external SRAM. Each access is split into two half-word phases: the low half first, then the high half. The block sits between the control path's `mem_read`/`mem_write` strobes and the SRAM pins. It holds `ready` low while a transaction is in flight; the pipeline uses that to freeze every stage and hold its MEM-stage inputs stable.

## Interface
Parameters:
- `SRAM_ADDR_W`, default 18: SRAM half-word address width.
- `WAIT_CYCLES`, default 2: cycles per half-word phase. Must be at least 1.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous and active-low.
- `mem_read`, in, 1: word read request, level-sensitive.
- `mem_write`, in, 1: word write request, level-sensitive. Has priority over `mem_read`.
- `addr`, in, 32: byte address. Bits [1:0] are ignored; bits above `SRAM_ADDR_W` are ignored.
- `wdata`, in, 32: write data.
- `rdata`, out, 32: read data. Registered.
- `ready`, out, 1: 0 means freeze the pipeline.
- `sram_addr`, out, `SRAM_ADDR_W`: SRAM half-word address.
- `sram_dq_o`, out, 16: write data driven to the SRAM.
- `sram_dq_i`, in, 16: read data returned from the SRAM.
- `sram_dq_oe`, out, 1: enables the pad drivers for `sram_dq_o`.
- `sram_we_n`, out, 1: SRAM write enable, active-low.
- `sram_oe_n`, out, 1: SRAM output enable, active-low.

## Operation
- **States:** IDLE, LOW, HIGH, DONE.
- **Held registers:** `op` (1 = write), `word_idx` (`SRAM_ADDR_W`-1 bits), `wbuf` (32), `cnt` (wide enough to count to `WAIT_CYCLES`-1), `rdata`.
- **Reset values:** state IDLE; `cnt`, `op`, `word_idx`, `wbuf` and `rdata` all 0. Outputs: `ready`=1, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1.
- **IDLE:**
  - `ready` = !(`mem_read` | `mem_write`), combinational.
  - If a request is present, latch `op` = `mem_write`, `word_idx` = `addr[SRAM_ADDR_W:2]` and `wbuf` = `wdata`; clear `cnt`; go to LOW.
- **LOW:**
  - `sram_addr` = {`word_idx`, 0}.
  - Write: `sram_dq_o` = `wbuf[15:0]`, `sram_dq_oe`=1, `sram_we_n`=0.
  - Read: `sram_oe_n`=0.
  - `cnt` increments each cycle. When `cnt` = `WAIT_CYCLES`-1: clear `cnt`, go to HIGH, and on a read capture `rdata[15:0]` = `sram_dq_i`.
- **HIGH:** same as LOW, except `sram_addr` = {`word_idx`, 1}, write data is `wbuf[31:16]`, and a read captures into `rdata[31:16]`. Exit goes to DONE.
- **DONE:** `ready`=1, all SRAM strobes inactive. Go to IDLE unconditionally. A request still present in DONE is not re-accepted, because the pipeline advances on this edge.
- **`ready` in LOW and HIGH:** 0.
- **Strobes outside LOW and HIGH:** all inactive. `sram_addr` and `sram_dq_o` hold 0 in IDLE and DONE.
- **Input changes mid-transaction:** changes on `addr`, `wdata`, `mem_read` and `mem_write` while in LOW or HIGH have no effect. The transaction runs on the latched values.
- **Both requests asserted:** performed as a write.
- **`rdata` holding:** holds its value through writes and idle periods. It is updated only at read phase exits.
- **`rst_n` low mid-transaction:** immediately forces the reset values, including `sram_we_n`=1 and `sram_dq_oe`=0. The transaction is abandoned, and a write may leave a partial word in the SRAM.

## Timing
- A request first seen in IDLE at cycle 0 drives `ready`=0 in cycle 0.
- With W = `WAIT_CYCLES`:
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE is cycle 2W+1, with `ready`=1.
- The freeze lasts exactly 2W+1 cycles.
- Read data is fully valid in `rdata` from cycle 2W+1 (DONE) onward.
- **Back-to-back requests:** the next request is seen in IDLE at cycle 2W+2. The minimum spacing between access starts is 2W+2 cycles.
- **SRAM pin stability:** `sram_addr` changes only at phase boundaries. Each half-word address is held for exactly W cycles.

## Test plan
- **Reset and idle.** Assert `rst_n`=0, then release with no requests. Required: `ready`=1, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `rdata`=0 throughout.
- **Write, W=2.** `mem_write`=1, `addr`=0x00000404, `wdata`=0xDEADBEEF. Required:
  - `ready` low in cycles 0-4 and high in cycle 5.
  - Cycles 1-2: `sram_addr`=0x202, `sram_dq_o`=0xBEEF, `sram_we_n`=0.
  - Cycles 3-4: `sram_addr`=0x203, `sram_dq_o`=0xDEAD.
- **Read back.** `mem_read`=1, `addr`=0x00000404, with an SRAM model holding the data written above. Required: `rdata`=0xDEADBEEF in cycle 5, and `sram_oe_n`=0 in cycles 1-4 only.
- **Both requests and input change.** `mem_read`=`mem_write`=1 at `addr` 0x8. Required: the access is a write to `sram_addr` 0x4/0x5. Changing `addr` to 0x10 in cycle 2 has no effect on `sram_addr`.
- **Back-to-back.** Write to 0x0 held through DONE, then a read of 0x0 presented. Required: exactly one write; the next access starts in cycle 6; `rdata` returns the written word.
- **Reset mid-write.** Drive `rst_n` low in cycle 3 of a write. Required: `sram_we_n`=1 and `sram_dq_oe`=0 immediately. After release: `ready`=1 and state IDLE.
